pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the MiniMIPS32 pipeline, succeeding the fixed per-stage registers (IF_ID, ID_EX, EX_MEM, ...).
- Carries an opaque payload bus, a valid bit, a delay-slot flag and exception side-band (code, EPC, BadVAddr).
- Obeys the core-wide stall vector and flush.
- Adds three things the fixed registers lack: explicit valid tracking, a hold state machine with a stuck-stall watchdog, and selectable bubble contents.

Parameters:
- DATA_W, 64, payload width in bits.
- STALL_W, 6, width of the core stall vector.
- STAGE_IDX, 2, index of the upstream stage in the stall vector; the downstream stage is STAGE_IDX+1. Legal range 0..STALL_W-2.
- EXC_W, 5, exception code width; must equal `EXC_CODE_WIDTH.
- EXC_NONE, 0, exception code loaded on reset, flush and bubble.
- BUBBLE_DATA, 0, payload value loaded on reset, flush and bubble (DATA_W bits).
- HOLD_LIMIT, 1023, number of consecutive hold cycles before timeout; 1..65535.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-low reset (`RstEnable = 0).
- stall  in  STALL_W  core stall vector, bit=1 means stop.
- flush  in  1  synchronous pipeline flush from the exception unit.
- data_i  in  DATA_W  upstream payload.
- valid_i  in  1  upstream payload is a real instruction.
- ds_i  in  1  upstream instruction is in a delay slot.
- exc_code_i  in  EXC_W  upstream exception code.
- exc_epc_i  in  32  upstream EPC.
- exc_badvaddr_i  in  32  upstream BadVAddr.
- data_o  out  DATA_W  registered payload.
- valid_o  out  1  registered valid.
- ds_o  out  1  registered delay-slot flag.
- exc_code_o  out  EXC_W  registered exception code.
- exc_epc_o  out  32  registered EPC.
- exc_badvaddr_o  out  32  registered BadVAddr.
- held_o  out  1  high while the FSM is in HELD.
- hold_timeout_o  out  1  sticky stuck-stall indication.

Behaviour:
- Reset (rst=0, asynchronous), all outputs:
  - data_o=BUBBLE_DATA, valid_o=0, ds_o=0
  - exc_code_o=EXC_NONE, exc_epc_o=0, exc_badvaddr_o=0
  - held_o=0, hold_timeout_o=0
  - FSM=EMPTY, hold counter=0.
  - Reset asserted mid-hold aborts immediately with the same values.
- Action per rising edge, evaluated in priority order:
  1. flush=1 -> CLEAR.
  2. stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0 -> BUBBLE.
  3. stall[STAGE_IDX]=0 -> LOAD.
  4. Otherwise -> HOLD.
- CLEAR and BUBBLE: outputs take their reset values except hold_timeout_o. CLEAR also clears hold_timeout_o; BUBBLE leaves it unchanged.
- LOAD: all *_i are copied to *_o in one cycle.
  - If valid_i=0, the payload is still copied, but exc_code_o is forced to EXC_NONE and ds_o to 0, so an invalid slot never raises an exception.
- HOLD: all data outputs keep their values.
- Latency: exactly 1 cycle from input to output on LOAD. No combinational path from any input to any output.
- FSM states:
  - EMPTY: valid_o=0.
  - FULL: valid_o=1, advancing.
  - HELD: valid_o=1 and a HOLD action occurred.
- FSM transitions:
  - CLEAR or BUBBLE -> EMPTY.
  - LOAD with valid_i=1 -> FULL.
  - LOAD with valid_i=0 -> EMPTY.
  - HOLD while FULL or HELD -> HELD.
  - HOLD while EMPTY -> EMPTY.
- held_o = (state==HELD).
- Hold counter:
  - Increments by 1 on every HOLD edge in HELD, saturating at HOLD_LIMIT.
  - Cleared on any non-HOLD action.
  - hold_timeout_o sets on the edge where the counter reaches HOLD_LIMIT. It stays set until a flush or a reset; a LOAD does not clear it.
- Simultaneous flush and stall: flush wins.
- Stall vector with stall[STAGE_IDX]=0 and stall[STAGE_IDX+1]=1 is illegal in this core. Behaviour is LOAD (rule 3); the bench flags it as an assertion failure.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, adds three outputs:
  - bubble_cnt_o [31:0]: BUBBLE actions.
  - flush_cnt_o [31:0]: CLEAR actions caused by flush.
  - hold_cnt_o [31:0]: total HOLD edges while HELD.
- All three reset to 0 and saturate at 32'hFFFFFFFF.
- When undefined, these ports and their registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, stall=6'b000000, data_i=64'hA5, valid_i=1, exc_code_i=0 -> next edge: data_o=64'hA5, valid_o=1, state FULL.
- Loaded 64'hA5; stall=6'b001100 (STAGE_IDX=2) for 3 edges -> data_o holds 64'hA5, held_o=1, valid_o=1; on release the next data_i=64'hB6 appears one edge later.
- stall=6'b000100 -> next edge: data_o=BUBBLE_DATA, valid_o=0, exc_code_o=EXC_NONE, held_o=0.
- flush=1 together with stall=6'b000000 and exc_code_i=5'h0C -> next edge: all outputs at reset values, exc_code_o=EXC_NONE.
- LOAD with valid_i=0, exc_code_i=5'h04, ds_i=1 -> exc_code_o=EXC_NONE, ds_o=0, valid_o=0.
- HOLD_LIMIT=4, hold for 5 edges while FULL -> hold_timeout_o rises on the 4th HOLD edge, stays set after a LOAD, clears on flush. With PIPE_STAGE_STATS_EN defined, hold_cnt_o=5 at that point.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Bus bundle for one pipe_stage_reg instance.
// Carries the core stall/flush controls, the upstream payload and exception
// side-band, and the registered outputs of the stage.
// The slave modport is the stage itself. The master modport is whatever drives
// the stage and consumes its outputs.
// The statistics counters exist only when PIPE_STAGE_STATS_EN is defined.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 64,
  parameter int STALL_W = 6,
  parameter int EXC_W   = 5
);

  logic [STALL_W-1:0] stall;
  logic               flush;

  logic [DATA_W-1:0]  data_i;
  logic               valid_i;
  logic               ds_i;
  logic [EXC_W-1:0]   exc_code_i;
  logic [31:0]        exc_epc_i;
  logic [31:0]        exc_badvaddr_i;

  logic [DATA_W-1:0]  data_o;
  logic               valid_o;
  logic               ds_o;
  logic [EXC_W-1:0]   exc_code_o;
  logic [31:0]        exc_epc_o;
  logic [31:0]        exc_badvaddr_o;
  logic               held_o;
  logic               hold_timeout_o;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]        bubble_cnt_o;
  logic [31:0]        flush_cnt_o;
  logic [31:0]        hold_cnt_o;
`endif

  // Upstream side: drives controls and payload, observes the stage outputs
  modport master (
    output stall, flush,
    output data_i, valid_i, ds_i, exc_code_i, exc_epc_i, exc_badvaddr_i,
    input  data_o, valid_o, ds_o, exc_code_o, exc_epc_o, exc_badvaddr_o,
    input  held_o, hold_timeout_o
`ifdef PIPE_STAGE_STATS_EN
    ,
    input  bubble_cnt_o, flush_cnt_o, hold_cnt_o
`endif
  );

  // The pipeline register itself
  modport slave (
    input  stall, flush,
    input  data_i, valid_i, ds_i, exc_code_i, exc_epc_i, exc_badvaddr_i,
    output data_o, valid_o, ds_o, exc_code_o, exc_epc_o, exc_badvaddr_o,
    output held_o, hold_timeout_o
`ifdef PIPE_STAGE_STATS_EN
    ,
    output bubble_cnt_o, flush_cnt_o, hold_cnt_o
`endif
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised MiniMIPS32 inter-stage pipeline register.
// Registers an opaque payload, a valid bit, a delay-slot flag and the
// exception side-band between two pipeline stages.
// It obeys the core stall vector and flush, and tracks occupancy with an
// EMPTY/FULL/HELD state machine. A stuck-stall watchdog raises a sticky
// hold_timeout_o after HOLD_LIMIT consecutive hold cycles.
// Optional macro PIPE_STAGE_STATS_EN adds saturating bubble/flush/hold
// event counters.

`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif

module pipe_stage_reg #(
  parameter int                  DATA_W      = 64,
  parameter int                  STALL_W     = 6,
  parameter int                  STAGE_IDX   = 2,
  parameter int                  EXC_W       = `EXC_CODE_WIDTH,
  parameter logic [EXC_W-1:0]    EXC_NONE    = '0,
  parameter logic [DATA_W-1:0]   BUBBLE_DATA = '0,
  parameter int                  HOLD_LIMIT  = 1023
) (
  input  logic          clk,
  input  logic          rst,
  pipe_stage_reg_if.slave bus
);

  // Occupancy states; kept as plain constants so downstream tools that
  // probe the state register see stable legacy codes.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  // Per-edge action, resolved from flush and the two relevant stall bits.
  localparam logic [1:0] ACT_CLEAR  = 2'd0;
  localparam logic [1:0] ACT_BUBBLE = 2'd1;
  localparam logic [1:0] ACT_LOAD   = 2'd2;
  localparam logic [1:0] ACT_HOLD   = 2'd3;

  localparam logic [15:0] HOLD_MAX = 16'(HOLD_LIMIT);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [1:0]        action;
  logic              stall_up;
  logic              stall_dn;
  logic              hold_step;
  logic [15:0]       hold_run_q;
  logic [15:0]       hold_run_inc;
  logic              timeout_q;

  logic [DATA_W-1:0] data_q;
  logic              ds_q;
  logic [EXC_W-1:0]  exc_code_q;
  logic [31:0]       exc_epc_q;
  logic [31:0]       exc_badvaddr_q;

  // Only two bits of the shared stall vector matter to this stage.
  logic              stall_unused;
  assign stall_unused = ^bus.stall;

  assign stall_up = bus.stall[STAGE_IDX];
  assign stall_dn = bus.stall[STAGE_IDX+1];

  // Resolve the action for this edge: flush beats everything. A stalled
  // upstream with a free downstream inserts a bubble. A running upstream
  // loads. Otherwise the stage holds its contents.
  always_comb begin
    action = ACT_HOLD;
    if (bus.flush) begin
      action = ACT_CLEAR;
    end else if (stall_up && !stall_dn) begin
      action = ACT_BUBBLE;
    end else if (!stall_up) begin
      action = ACT_LOAD;
    end
  end

  // A counted hold edge is one that leaves real contents parked in place;
  // holding an empty slot does not feed the watchdog.
  assign hold_step    = (action == ACT_HOLD) && (state_q != ST_EMPTY);
  assign hold_run_inc = (hold_run_q == HOLD_MAX) ? hold_run_q : hold_run_q + 16'd1;

  // Next occupancy state from the resolved action and incoming valid bit.
  always_comb begin
    state_d = state_q;
    case (action)
      ACT_CLEAR, ACT_BUBBLE: state_d = ST_EMPTY;
      ACT_LOAD:              state_d = bus.valid_i ? ST_FULL : ST_EMPTY;
      default:               state_d = (state_q == ST_EMPTY) ? ST_EMPTY : ST_HELD;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload and side-band register; an invalid slot is scrubbed of its
  // exception code and delay-slot flag so it can never trap downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q         <= BUBBLE_DATA;
      ds_q           <= 1'b0;
      exc_code_q     <= EXC_NONE;
      exc_epc_q      <= 32'd0;
      exc_badvaddr_q <= 32'd0;
    end else begin
      case (action)
        ACT_CLEAR, ACT_BUBBLE: begin
          data_q         <= BUBBLE_DATA;
          ds_q           <= 1'b0;
          exc_code_q     <= EXC_NONE;
          exc_epc_q      <= 32'd0;
          exc_badvaddr_q <= 32'd0;
        end
        ACT_LOAD: begin
          data_q         <= bus.data_i;
          ds_q           <= bus.valid_i ? bus.ds_i : 1'b0;
          exc_code_q     <= bus.valid_i ? bus.exc_code_i : EXC_NONE;
          exc_epc_q      <= bus.exc_epc_i;
          exc_badvaddr_q <= bus.exc_badvaddr_i;
        end
        default: begin
          data_q         <= data_q;
          ds_q           <= ds_q;
          exc_code_q     <= exc_code_q;
          exc_epc_q      <= exc_epc_q;
          exc_badvaddr_q <= exc_badvaddr_q;
        end
      endcase
    end
  end

  // Consecutive-hold run length, saturating; any non-hold action restarts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_run_q <= 16'd0;
    end else if (action != ACT_HOLD) begin
      hold_run_q <= 16'd0;
    end else if (hold_step) begin
      hold_run_q <= hold_run_inc;
    end
  end

  // Sticky watchdog flag: set when the run reaches the limit, cleared only
  // by flush or reset so software can still see it after the pipe recovers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if (action == ACT_CLEAR) begin
      timeout_q <= 1'b0;
    end else if (hold_step && (hold_run_inc == HOLD_MAX)) begin
      timeout_q <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] hold_cnt_q;

  // Saturating event counters for performance analysis
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= 32'd0;
      flush_cnt_q  <= 32'd0;
      hold_cnt_q   <= 32'd0;
    end else begin
      if (action == ACT_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
      if (action == ACT_CLEAR && flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
      if (hold_step && hold_cnt_q != 32'hFFFF_FFFF) begin
        hold_cnt_q <= hold_cnt_q + 32'd1;
      end
    end
  end

  assign bus.bubble_cnt_o = bubble_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;
  assign bus.hold_cnt_o   = hold_cnt_q;
`endif

  assign bus.data_o         = data_q;
  assign bus.valid_o        = (state_q != ST_EMPTY);
  assign bus.ds_o           = ds_q;
  assign bus.exc_code_o     = exc_code_q;
  assign bus.exc_epc_o      = exc_epc_q;
  assign bus.exc_badvaddr_o = exc_badvaddr_q;
  assign bus.held_o         = (state_q == ST_HELD);
  assign bus.hold_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg (STAGE_IDX=2, HOLD_LIMIT=4).
// Directed walk through the main scenarios, then randomized traffic.
// Every edge is compared against a behavioural occupancy model.
module tb_pipe_stage_reg;

  localparam int S     = 2;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  int checks;
  int errors;

  pipe_stage_reg_if #(.DATA_W(64), .STALL_W(6), .EXC_W(5)) bus ();

  pipe_stage_reg #(
    .DATA_W(64), .STALL_W(6), .STAGE_IDX(S), .EXC_W(5),
    .EXC_NONE(5'd0), .BUBBLE_DATA(64'd0), .HOLD_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model state: what the stage should be presenting right now
  logic [63:0] m_data;
  logic        m_occupied;
  logic        m_ds;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [31:0] m_bva;
  logic        m_held;
  int          m_run;
  logic        m_timeout;
  longint      m_bubbles;
  longint      m_flushes;
  longint      m_holds;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    m_data = 64'd0; m_occupied = 1'b0; m_ds = 1'b0; m_code = 5'd0;
    m_epc = 32'd0; m_bva = 32'd0; m_held = 1'b0; m_run = 0; m_timeout = 1'b0;
    m_bubbles = 0; m_flushes = 0; m_holds = 0;
  endtask

  task automatic modelEmpty();
    m_data = 64'd0; m_occupied = 1'b0; m_ds = 1'b0; m_code = 5'd0;
    m_epc = 32'd0; m_bva = 32'd0; m_held = 1'b0; m_run = 0;
  endtask

  // Predict the effect of the coming rising edge from the current inputs
  task automatic modelStep();
    logic up;
    logic dn;
    up = bus.stall[S];
    dn = bus.stall[S+1];
    if (bus.flush) begin
      modelEmpty();
      m_timeout = 1'b0;
      m_flushes++;
    end else if (up && !dn) begin
      modelEmpty();
      m_bubbles++;
    end else if (!up) begin
      m_data     = bus.data_i;
      m_occupied = bus.valid_i;
      m_ds       = bus.valid_i & bus.ds_i;
      m_code     = bus.valid_i ? bus.exc_code_i : 5'd0;
      m_epc      = bus.exc_epc_i;
      m_bva      = bus.exc_badvaddr_i;
      m_held     = 1'b0;
      m_run      = 0;
    end else if (m_occupied) begin
      m_held = 1'b1;
      m_run  = (m_run < LIMIT) ? m_run + 1 : LIMIT;
      if (m_run == LIMIT) m_timeout = 1'b1;
      m_holds++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".data"},    bus.data_o,                 m_data);
    checkOutput({tag, ".valid"},   64'(bus.valid_o),           64'(m_occupied));
    checkOutput({tag, ".ds"},      64'(bus.ds_o),              64'(m_ds));
    checkOutput({tag, ".code"},    64'(bus.exc_code_o),        64'(m_code));
    checkOutput({tag, ".epc"},     64'(bus.exc_epc_o),         64'(m_epc));
    checkOutput({tag, ".bva"},     64'(bus.exc_badvaddr_o),    64'(m_bva));
    checkOutput({tag, ".held"},    64'(bus.held_o),            64'(m_held));
    checkOutput({tag, ".timeout"}, 64'(bus.hold_timeout_o),    64'(m_timeout));
`ifdef PIPE_STAGE_STATS_EN
    checkOutput({tag, ".nbub"},    64'(bus.bubble_cnt_o),      64'(m_bubbles));
    checkOutput({tag, ".nflush"},  64'(bus.flush_cnt_o),       64'(m_flushes));
    checkOutput({tag, ".nhold"},   64'(bus.hold_cnt_o),        64'(m_holds));
`endif
  endtask

  // Drive one edge's worth of inputs, predict, clock, then compare
  task automatic applyStimulus(input string tag, input logic [5:0] stall,
                               input logic flush, input logic [63:0] data,
                               input logic valid, input logic ds,
                               input logic [4:0] code, input logic [31:0] epc,
                               input logic [31:0] bva);
    assert (!(stall[S] == 1'b0 && stall[S+1] == 1'b1))
    else $error("[TB] illegal stall vector %b driven at %s", stall, tag);
    bus.stall = stall; bus.flush = flush; bus.data_i = data;
    bus.valid_i = valid; bus.ds_i = ds; bus.exc_code_i = code;
    bus.exc_epc_i = epc; bus.exc_badvaddr_i = bva;
    modelStep();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [5:0] st;
    int         kind;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.stall = '0; bus.flush = 1'b0; bus.data_i = '0; bus.valid_i = 1'b0;
    bus.ds_i = 1'b0; bus.exc_code_i = '0; bus.exc_epc_i = '0; bus.exc_badvaddr_i = '0;
    modelReset();
    #12;
    checkAll("reset");
    rst = 1'b1;

    applyStimulus("load_a5", 6'b000000, 1'b0, 64'hA5, 1'b1, 1'b0, 5'd0, 32'h100, 32'h0);
    checkOutput("load_a5.const", bus.data_o, 64'hA5);

    for (int i = 0; i < 3; i++)
      applyStimulus("hold", 6'b001100, 1'b0, 64'hDEAD, 1'b1, 1'b1, 5'd3, 32'h1, 32'h2);
    checkOutput("hold.const_data", bus.data_o, 64'hA5);
    checkOutput("hold.const_held", 64'(bus.held_o), 64'd1);

    applyStimulus("load_b6", 6'b000000, 1'b0, 64'hB6, 1'b1, 1'b0, 5'd0, 32'h104, 32'h0);
    checkOutput("load_b6.const", bus.data_o, 64'hB6);

    applyStimulus("bubble", 6'b000100, 1'b0, 64'h77, 1'b1, 1'b0, 5'd1, 32'h5, 32'h6);
    checkOutput("bubble.const_valid", 64'(bus.valid_o), 64'd0);

    applyStimulus("load_c7", 6'b000000, 1'b0, 64'hC7, 1'b1, 1'b1, 5'h0C, 32'h200, 32'h300);
    applyStimulus("flush", 6'b000000, 1'b1, 64'hE8, 1'b1, 1'b1, 5'h0C, 32'h9, 32'h9);
    checkOutput("flush.const_code", 64'(bus.exc_code_o), 64'd0);

    applyStimulus("invalid", 6'b000000, 1'b0, 64'h1234, 1'b0, 1'b1, 5'h04, 32'h40, 32'h44);
    checkOutput("invalid.const_code", 64'(bus.exc_code_o), 64'd0);

    applyStimulus("load_wd", 6'b000000, 1'b0, 64'hF00D, 1'b1, 1'b0, 5'd0, 32'h500, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus("wd_hold", 6'b001100, 1'b0, 64'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      if (i == 3) checkOutput("wd_h3.const_timeout", 64'(bus.hold_timeout_o), 64'd0);
      if (i == 4) checkOutput("wd_h4.const_timeout", 64'(bus.hold_timeout_o), 64'd1);
    end
    applyStimulus("wd_load", 6'b000000, 1'b0, 64'hAB, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    checkOutput("wd_load.const_timeout", 64'(bus.hold_timeout_o), 64'd1);
    applyStimulus("wd_flush", 6'b000000, 1'b1, 64'hAB, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    checkOutput("wd_flush.const_timeout", 64'(bus.hold_timeout_o), 64'd0);

    applyStimulus("pre_rst", 6'b000000, 1'b0, 64'h55, 1'b1, 1'b1, 5'h2, 32'h7, 32'h8);
    applyStimulus("pre_rst_hold", 6'b001100, 1'b0, 64'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    applyStimulus("pre_rst_hold", 6'b001100, 1'b0, 64'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkAll("mid_rst");
    #1;
    rst = 1'b1;

    kind = 0;
    for (int n = 0; n < 400; n++) begin
      st = 6'($urandom);
      if (kind == 2 && $urandom_range(0, 9) < 8) kind = 2;
      else kind = $urandom_range(0, 9) < 5 ? 0 : ($urandom_range(0, 2) == 0 ? 1 : 2);
      st[S]   = (kind != 0);
      st[S+1] = (kind == 2);
      applyStimulus("rand", st, $urandom_range(0, 15) == 0, {$urandom, $urandom},
                    1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
